// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between instruction
// fetch (F) and data access (M). Data wins when both are pending because it
// belongs to the older instruction. Each access runs to completion on the
// port, and returned data lands in hold registers. Per-stage stall requests
// stay high until that stage's access has completed.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    // fetch side
    input  logic          IReqF,
    input  logic [AW-1:0] PCF,
    input  logic          AdvanceF,
    output logic [DW-1:0] InstrF,
    output logic          IStall,
    // data side
    input  logic          DReqM,
    input  logic          DWeM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    input  logic          AdvanceM,
    output logic [DW-1:0] ReadDataM,
    output logic          DStall,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_i_done;
    logic          r_d_done;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_rdata;

    logic          w_i_pend;
    logic          w_d_pend;
    logic          w_load_i;
    logic          w_load_d;
    logic          w_cpl_i;
    logic          w_cpl_d;

    // A requester is pending while it asks and its result is not yet held.
    assign w_i_pend = IReqF & ~r_i_done;
    assign w_d_pend = DReqM & ~r_d_done;

    assign IStall    = w_i_pend;
    assign DStall    = w_d_pend;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign InstrF    = r_instr;
    assign ReadDataM = r_rdata;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection plus load/complete strobes; a finishing access
    // hands the port straight to the other pending requester, never itself.
    always_comb begin
        w_state_nxt = r_state;
        w_load_i    = 1'b0;
        w_load_d    = 1'b0;
        w_cpl_i     = 1'b0;
        w_cpl_d     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_pend) begin
                    w_state_nxt = ST_BUSY_D;
                    w_load_d    = 1'b1;
                end else if (w_i_pend) begin
                    w_state_nxt = ST_BUSY_I;
                    w_load_i    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY_I: begin
                if (mem_ready) begin
                    w_cpl_i = 1'b1;
                    if (w_d_pend) begin
                        w_state_nxt = ST_BUSY_D;
                        w_load_d    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    w_cpl_d = 1'b1;
                    if (w_i_pend) begin
                        w_state_nxt = ST_BUSY_I;
                        w_load_i    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_BUSY_D;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request registers: loaded on entry to a busy state, frozen while the
    // memory stalls, request dropped once the port goes idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_load_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= DWeM;
            r_mem_addr  <= ALUResultM;
            r_mem_wdata <= WriteDataM;
        end else if (w_load_i) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= PCF;
            r_mem_wdata <= '0;
        end else if (w_cpl_i || w_cpl_d) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Hold registers: a flushed access still updates them; stores leave
    // the load data untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= '0;
            r_rdata <= '0;
        end else begin
            if (w_cpl_i) begin
                r_instr <= mem_rdata;
            end
            if (w_cpl_d && !r_mem_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Done flags: set on completion if the requester still asks (set beats
    // a same-edge advance), cleared when the stage advances.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            if (w_cpl_i && IReqF) begin
                r_i_done <= 1'b1;
            end else if (AdvanceF) begin
                r_i_done <= 1'b0;
            end
            if (w_cpl_d && DReqM) begin
                r_d_done <= 1'b1;
            end else if (AdvanceM) begin
                r_d_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table (inputs for
// the cycle plus the outputs expected in that same cycle) followed by a
// hand-written asynchronous-reset-during-access sequence.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        IReqF;
    logic [31:0] PCF;
    logic        AdvanceF;
    logic [31:0] InstrF;
    logic        IStall;
    logic        DReqM;
    logic        DWeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        AdvanceM;
    logic [31:0] ReadDataM;
    logic        DStall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_tests;
    int n_fail;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .IReqF(IReqF), .PCF(PCF), .AdvanceF(AdvanceF),
        .InstrF(InstrF), .IStall(IStall),
        .DReqM(DReqM), .DWeM(DWeM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .AdvanceM(AdvanceM),
        .ReadDataM(ReadDataM), .DStall(DStall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] pc;
        logic        advf;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic        advm;
        logic [31:0] rdata;
        logic        ready;
        logic        e_istall;
        logic        e_dstall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_instr;
        logic [31:0] e_rdm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ireq, input logic [31:0] pc, input logic advf,
                       input logic dreq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] wdata, input logic advm,
                       input logic [31:0] rdata, input logic ready,
                       input logic e_ist, input logic e_dst, input logic e_req,
                       input logic e_we, input logic [31:0] e_addr,
                       input logic [31:0] e_wd, input logic [31:0] e_instr,
                       input logic [31:0] e_rdm);
        vec_t v;
        v.ireq = ireq; v.pc = pc; v.advf = advf;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.wdata = wdata; v.advm = advm;
        v.rdata = rdata; v.ready = ready;
        v.e_istall = e_ist; v.e_dstall = e_dst; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wd; v.e_instr = e_instr; v.e_rdm = e_rdm;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //  ireq pc          advf dreq dwe daddr       wdata        advm rdata        rdy | ist dst req we addr        wdata        instr        rdm
        // single fetch, immediate ready, then done-hold for 3 cycles, then next PC
        add(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0);
        add(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hE3A01005, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        32'h0);
        add(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'hE3A01005, 32'h0);
        add(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'hE3A01005, 32'h0);
        add(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'hE3A01005, 32'h0);
        add(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'hE3A01005, 32'h0);
        add(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'hE3A01005, 32'h0);
        add(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0,        32'hE3A01005, 32'h0);
        add(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h11111111, 32'h0);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h11111111, 32'h0);
        // simultaneous: D first, then I back-to-back with no idle gap
        add(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h11111111, 32'h0);
        add(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'hAAAA5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0,        32'h11111111, 32'h0);
        add(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0,        32'h11111111, 32'hAAAA5555);
        add(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h0BADF00D, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0,        32'h11111111, 32'hAAAA5555);
        add(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hAAAA5555);
        // store with 3 wait states; inputs change mid-access, port must not
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44,  32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44,  32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44,  32'h12345678, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hAAAA5555);
        // flushed load: completes on the port, updates ReadDataM, no done
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h300, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h300, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0,        32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h300, 32'h0,        1'b0, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0,        32'h0BADF00D, 32'hAAAA5555);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hCAFE0001);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h304, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'hCAFE0001);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h304, 32'h0,        1'b0, 32'h00000042, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h304, 32'h0,        32'h0BADF00D, 32'hCAFE0001);
        add(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h304, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'h00000042);
        add(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 32'h00000042);

        // reset state; IStall must follow IReqF even in reset
        reset_n = 1'b0;
        IReqF = 1'b1; PCF = 32'h0; AdvanceF = 1'b0;
        DReqM = 1'b0; DWeM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0; AdvanceM = 1'b0;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        #12;
        chk("rst_istall", {31'd0, IStall}, 32'd1);
        chk("rst_dstall", {31'd0, DStall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_rdm", ReadDataM, 32'h0);
        IReqF = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            IReqF = vecs[i].ireq; PCF = vecs[i].pc; AdvanceF = vecs[i].advf;
            DReqM = vecs[i].dreq; DWeM = vecs[i].dwe; ALUResultM = vecs[i].daddr;
            WriteDataM = vecs[i].wdata; AdvanceM = vecs[i].advm;
            mem_rdata = vecs[i].rdata; mem_ready = vecs[i].ready;
            #1;
            chk($sformatf("v%0d_istall", i), {31'd0, IStall}, {31'd0, vecs[i].e_istall});
            chk($sformatf("v%0d_dstall", i), {31'd0, DStall}, {31'd0, vecs[i].e_dstall});
            chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_instr", i), InstrF, vecs[i].e_instr);
            chk($sformatf("v%0d_rdm", i), ReadDataM, vecs[i].e_rdm);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
                if (vecs[i].e_we) begin
                    chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
                end
            end
        end

        // reset while BUSY_I: port drops at once, fetch reissued afterwards
        @(negedge clk);
        IReqF = 1'b1; PCF = 32'h500; AdvanceF = 1'b0;
        DReqM = 1'b0; AdvanceM = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        #1;
        chk("busy_i_mem_req", {31'd0, mem_req}, 32'd1);
        chk("busy_i_mem_addr", mem_addr, 32'h500);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_instr", InstrF, 32'h0);
        chk("arst_rdm", ReadDataM, 32'h0);
        chk("arst_istall", {31'd0, IStall}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5 && !mem_req; k++) begin
            @(negedge clk);
        end
        #1;
        chk("reissue_mem_req", {31'd0, mem_req}, 32'd1);
        chk("reissue_mem_addr", mem_addr, 32'h500);
        mem_rdata = 32'h13579BDF; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("reissue_instr", InstrF, 32'h13579BDF);
        chk("reissue_istall", {31'd0, IStall}, 32'd0);
        chk("reissue_idle", {31'd0, mem_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one multi-cycle unified memory port between the instruction-fetch stage (F) and the data-memory stage (M) of the 5-stage pipeline. It serializes the two requesters, holds each address stable until the memory acknowledges, and captures returned data in hold registers. It generates per-stage stall requests that the hazard unit ORs into StallF/StallD/StallE/StallM. It sits between the pipeline datapath and the external memory interface.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- IReqF  input  1  fetch request valid
- PCF  input  AW  fetch address
- AdvanceF  input  1  F stage advances this cycle (~StallF from hazard unit)
- InstrF  output  DW  fetched instruction (hold register)
- IStall  output  1  fetch not yet complete
- DReqM  input  1  data request valid (load or store)
- DWeM  input  1  1 = store, 0 = load
- ALUResultM  input  AW  data address
- WriteDataM  input  DW  store data
- AdvanceM  input  1  M stage advances this cycle
- ReadDataM  output  DW  load data (hold register)
- DStall  output  1  data access not yet complete
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion, sampled only while mem_req = 1

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Flags i_done, d_done: set on completion of the respective access, cleared on edge where the matching Advance input is 1.
- Pending: i_pend = IReqF & ~i_done; d_pend = DReqM & ~d_done.
- IDLE: d_pend -> BUSY_D (data has priority, older instruction); else i_pend -> BUSY_I; else stay.
- On entering BUSY_x: latch address, we (0 for fetch), wdata into request registers; mem_req/mem_we/mem_addr/mem_wdata driven from these registers only.
- BUSY_x with mem_ready = 0: hold, registers unchanged.
- BUSY_x with mem_ready = 1: capture mem_rdata into InstrF (I) or ReadDataM (D, loads only; stores leave ReadDataM unchanged); set x_done if the request input is still 1, else discard (flushed). Next state: other requester pending -> its BUSY state directly, else IDLE. The just-completed requester is never reissued on the same edge.
- In-flight transactions are never aborted; a request dropped mid-access completes on the port and its result is discarded.
- Completion and Advance on the same edge for the same requester: done is set (set wins).
- IStall = i_pend; DStall = d_pend (combinational).

## Timing
- Reset (async, reset_n = 0): state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, InstrF 0, ReadDataM 0, i_done 0, d_done 0. IStall/DStall then follow IReqF/DReqM.
- Reset mid-access: port request dropped immediately; memory side must tolerate abandoned request.
- Minimum latency: request seen at cycle t, mem_req high at t+1, mem_ready at t+1 -> data in hold register and stall low at t+2.
- Each extra mem_ready = 0 cycle adds one cycle.
- Back-to-back D then I: no IDLE bubble between accesses.
- Address/we/wdata stable on every cycle mem_req = 1.

## Test plan
- Single fetch, mem_ready immediate: IReqF=1, PCF=0x100, rdata=0xE3A01005 -> mem_req at t+1, InstrF=0xE3A01005, IStall=0 at t+2.
- Simultaneous requests: IReqF=1 PCF=0x104, DReqM=1 DWeM=0 addr=0x200 -> D serviced first (mem_addr=0x200), then mem_addr=0x104 next cycle, no IDLE gap; DStall drops before IStall.
- Store with 3 wait states: DWeM=1 addr=0x40 wdata=0xDEADBEEF -> mem_req/addr/wdata stable 4 cycles, ReadDataM unchanged, DStall low one cycle after mem_ready.
- Done hold: fetch completes, AdvanceF=0 for 3 cycles -> no reissue, IStall=0, InstrF stable; AdvanceF=1 -> next PC fetched.
- Flushed request: DReqM drops while BUSY_D -> access completes, d_done stays 0, ReadDataM updated but no stall change.
- Reset in BUSY_I: reset_n=0 -> mem_req=0 and all outputs at reset values asynchronously; after release, pending fetch reissued.
